// File: rtl/output_arbiter_pkg.sv
// Shared cluster defaults for the output arbiter: core count, word width,
// core ID tag width and the round-robin index helper.
package output_arbiter_pkg;

  localparam int DEFAULT_NUM_CORES  = 8;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int CORE_ID_WIDTH      = 3;

  // Index reached by stepping offset places past base, wrapping modulo n.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/output_arbiter_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; empty/full are decoded
// from that count so a same-cycle pop never frees a slot for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/output_arbiter.sv
// Buffers each core's output words in a private FIFO and serialises them
// round-robin onto one tagged valid/ready stream.
module output_arbiter
  import output_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = DEFAULT_NUM_CORES,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ID_WIDTH   = CORE_ID_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_output_val,
  input  logic [NUM_CORES-1:0]            core_output_enable,
  output logic [NUM_CORES-1:0]            core_output_full,
  output logic [NUM_CORES-1:0]            overflow,
  input  logic                            overflow_clear,
  output logic [DATA_WIDTH-1:0]           out_val,
  output logic [ID_WIDTH-1:0]             out_core_id,
  output logic                            out_valid,
  input  logic                            out_ready
);

  // Handshake: a word transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready, out_val and out_core_id hold stable.

  logic [NUM_CORES-1:0]                 fifo_empty;
  logic [NUM_CORES-1:0]                 fifo_full;
  logic [NUM_CORES-1:0]                 fifo_push;
  logic [NUM_CORES-1:0]                 fifo_pop;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] fifo_dout;

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  grant_found;
  logic                  load;

  assign core_output_full = fifo_full;
  assign load = (!out_valid || out_ready) && grant_found;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_chan
    assign fifo_push[g] = core_output_enable[g] && !fifo_full[g];
    assign fifo_pop[g]  = load && (grant_idx == ID_WIDTH'(g));

    sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push[g]),
      .pop     (fifo_pop[g]),
      .din     (core_output_val[g*DATA_WIDTH +: DATA_WIDTH]),
      .dout    (fifo_dout[g]),
      .empty   (fifo_empty[g]),
      .full    (fifo_full[g])
    );
  end

  // First non-empty channel after the last grant, wrapping around.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = rr_index(int'(rr_ptr), k, NUM_CORES);
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!grant_found && (i == cand) && !fifo_empty[i]) begin
          grant_found = 1'b1;
          grant_idx   = ID_WIDTH'(i);
          grant_data  = fifo_dout[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_val     <= '0;
      out_core_id <= '0;
      rr_ptr      <= ID_WIDTH'(NUM_CORES - 1);
    end else if (load) begin
      out_valid   <= 1'b1;
      out_val     <= grant_data;
      out_core_id <= grant_idx;
      rr_ptr      <= grant_idx;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // A write is dropped when the registered count already shows full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= '0;
    end else if (overflow_clear) begin
      overflow <= '0;
    end else begin
      overflow <= overflow | (core_output_enable & fifo_full);
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Randomised and directed bench for output_arbiter against a queue-based model
// of the per-core buffers, round-robin grant and output register.
module tb_output_arbiter;

  localparam int N   = 8;
  localparam int W   = 16;
  localparam int D   = 4;
  localparam int IDW = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N*W-1:0]   core_output_val = '0;
  logic [N-1:0]     core_output_enable = '0;
  logic [N-1:0]     core_output_full;
  logic [N-1:0]     overflow;
  logic             overflow_clear = 1'b0;
  logic [W-1:0]     out_val;
  logic [IDW-1:0]   out_core_id;
  logic             out_valid;
  logic             out_ready = 1'b0;

  output_arbiter #(
    .NUM_CORES  (N),
    .DATA_WIDTH (W),
    .FIFO_DEPTH (D),
    .ID_WIDTH   (IDW)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .core_output_val    (core_output_val),
    .core_output_enable (core_output_enable),
    .core_output_full   (core_output_full),
    .overflow           (overflow),
    .overflow_clear     (overflow_clear),
    .out_val            (out_val),
    .out_core_id        (out_core_id),
    .out_valid          (out_valid),
    .out_ready          (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-core word queues, last-grant pointer, output register.
  logic [W-1:0]     mq [N][$];
  logic [IDW+W-1:0] exp_q [$];
  int               mptr = N - 1;
  logic             mvalid = 1'b0;
  logic [W-1:0]     mval = '0;
  int               mid = 0;
  logic [N-1:0]     movf = '0;
  logic [N-1:0]     pre_full;
  logic [N-1:0]     drop;
  int               gi;
  int               cand;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_q.delete();
      mptr = N - 1; mvalid = 1'b0; mval = '0; mid = 0; movf = '0;
    end else begin
      for (int i = 0; i < N; i++) pre_full[i] = (mq[i].size() == D);
      gi = -1;
      if (!mvalid || out_ready) begin
        for (int k = 1; k <= N; k++) begin
          cand = (mptr + k) % N;
          if (gi < 0 && mq[cand].size() > 0) gi = cand;
        end
      end
      if (gi >= 0) begin
        mval = mq[gi].pop_front();
        mid = gi; mvalid = 1'b1; mptr = gi;
        exp_q.push_back({IDW'(gi), mval});
      end else if (out_ready) begin
        mvalid = 1'b0;
      end
      drop = '0;
      for (int i = 0; i < N; i++) begin
        if (core_output_enable[i]) begin
          if (pre_full[i]) drop[i] = 1'b1;
          else mq[i].push_back(core_output_val[i*W +: W]);
        end
      end
      movf = overflow_clear ? '0 : (movf | drop);
    end
  end

  function automatic logic [N*W-1:0] one_word(input int core, input logic [W-1:0] w);
    logic [N*W-1:0] v;
    v = '0;
    v[core*W +: W] = w;
    return v;
  endfunction

  // Drive one cycle of inputs at a falling edge, then compare after the next rising edge.
  task automatic step(input logic [N-1:0] en, input logic [N*W-1:0] vals,
                      input logic rdy, input logic clr);
    logic [IDW+W-1:0] e;
    core_output_enable = en;
    core_output_val    = vals;
    out_ready          = rdy;
    overflow_clear     = clr;
    if (out_valid && rdy) begin
      check_eq("sb_pending", 32'(exp_q.size()), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("sb_word", 32'({out_core_id, out_val}), 32'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("valid", 32'(out_valid), 32'(mvalid));
    if (mvalid) begin
      check_eq("val", 32'(out_val), 32'(mval));
      check_eq("id", 32'(out_core_id), 32'(mid));
    end
    for (int i = 0; i < N; i++) check_eq("full", 32'(core_output_full[i]), 32'(mq[i].size() == D));
    check_eq("overflow", 32'(overflow), 32'(movf));
  endtask

  task automatic idle(input logic rdy);
    step('0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    core_output_enable = '0; core_output_val = '0; out_ready = 1'b0; overflow_clear = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_val", 32'(out_val), 0);
    check_eq("rst_id", 32'(out_core_id), 0);
    check_eq("rst_full", 32'(core_output_full), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    reset_n = 1'b1;
  endtask

  task automatic single_word();
    step(N'(1) << 3, one_word(3, 16'h1234), 1'b1, 1'b0);
    check_eq("s1_not_yet", 32'(out_valid), 0);
    idle(1'b1);
    check_eq("s1_valid", 32'(out_valid), 1);
    check_eq("s1_val", 32'(out_val), 32'h1234);
    check_eq("s1_id", 32'(out_core_id), 3);
    idle(1'b1);
    check_eq("s1_drop_valid", 32'(out_valid), 0);
  endtask

  logic [N*W-1:0] vals;
  logic [W-1:0]   wa, wb;

  initial begin
    // Single word from core 3
    do_reset();
    single_word();

    // All cores in one cycle: strict rotation from core 0
    do_reset();
    for (int i = 0; i < N; i++) vals[i*W +: W] = W'(i << 8);
    step('1, vals, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) begin
      idle(1'b1);
      check_eq("s2_valid", 32'(out_valid), 1);
      check_eq("s2_id", 32'(out_core_id), 32'(k));
      check_eq("s2_val", 32'(out_val), 32'(k << 8));
    end
    idle(1'b1);
    check_eq("s2_end", 32'(out_valid), 0);

    // Back-pressure hold on core 5
    do_reset();
    wa = W'($urandom); wb = W'($urandom);
    step(N'(1) << 5, one_word(5, wa), 1'b0, 1'b0);
    step(N'(1) << 5, one_word(5, wb), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_eq("s3_hold", 32'(out_val), 32'(wa));
      check_eq("s3_hold_valid", 32'(out_valid), 1);
      if (k < 3) idle(1'b0);
    end
    idle(1'b1);
    check_eq("s3_second", 32'(out_val), 32'(wb));
    idle(1'b1);
    check_eq("s3_end", 32'(out_valid), 0);

    // Overflow on core 2 behind a stalled word from core 7
    do_reset();
    step(N'(1) << 7, one_word(7, W'($urandom)), 1'b0, 1'b0);
    idle(1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(N'(1) << 2, one_word(2, W'(16'h2000 + k)), 1'b0, 1'b0);
      if (k == 4) check_eq("s4_full", 32'(core_output_full[2]), 1);
    end
    check_eq("s4_ovf", 32'(overflow[2]), 1);
    step('0, '0, 1'b0, 1'b1);
    check_eq("s4_clear", 32'(overflow), 0);
    repeat (8) idle(1'b1);
    check_eq("s4_drained", 32'(out_valid), 0);

    // Cores 0 and 1 writing together alternate grants
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      vals = one_word(0, W'($urandom)) | one_word(1, W'($urandom));
      step(N'(3), vals, 1'b1, 1'b0);
      if (k >= 2) check_eq("s5_alt", 32'(out_core_id), 32'((k - 2) % 2));
    end
    check_eq("s5_no_ovf", 32'(overflow), 0);
    repeat (10) idle(1'b1);

    // Asynchronous reset while words are buffered and held
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) vals[i*W +: W] = W'($urandom);
      step(N'(4'hf), vals, 1'b0, 1'b0);
    end
    check_eq("s6_held", 32'(out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("s6_rst_valid", 32'(out_valid), 0);
    check_eq("s6_rst_full", 32'(core_output_full), 0);
    core_output_enable = '0; out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) idle(1'b1);
    check_eq("s6_no_stale", 32'(out_valid), 0);
    single_word();

    // Random traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] en;
      for (int i = 0; i < N; i++) vals[i*W +: W] = W'($urandom);
      en = N'($urandom) & N'($urandom);
      step(en, vals, $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0);
    end
    repeat (40) idle(1'b1);
    check_eq("final_valid", 32'(out_valid), 0);
    check_eq("final_pending", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
